// File: rtl/floatingpoint.sv
// Shared floating-point package: the float type, the quiet-NaN constant
// returned on a watchdog expiry, and the issue-stage state encoding.
package floatingpoint;

  typedef logic [31:0] float;

  // Canonical single-precision quiet NaN
  localparam float FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/fp_req_fifo.sv
// Small synchronous FIFO with a combinational head view. The same block is
// meant to sit on the result side later, so the width is a parameter.
module fp_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 68
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  // Requests that arrive when full or pops when empty are ignored
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write; contents need no reset since occupancy is tracked separately
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

endmodule

// File: rtl/fp_add_issue_queue.sv
// Issue stage in front of the multi-cycle FloatAdder: queues tagged operand
// pairs, issues one at a time, waits for the result (ignoring stale valids
// for MIN_LAT cycles) and returns quiet NaN if the adder never answers.
module fp_add_issue_queue
  import floatingpoint::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int MIN_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [31:0]            InOp1,
  input  logic [31:0]            InOp2,
  input  logic [TAG_W-1:0]       InTag,
  output logic [31:0]            AddOp1,
  output logic [31:0]            AddOp2,
  output logic                   AddInputValid,
  input  logic [31:0]            AddResult,
  input  logic                   AddResultValid,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [31:0]            OutResult,
  output logic [TAG_W-1:0]       OutTag,
  output logic                   OutTimeout,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MIN_LAT_C = CW'(MIN_LAT);
  localparam logic [CW-1:0] LAST_C    = CW'(TIMEOUT - 1);

  issue_state_t      state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [31:0]       add_op1_reg, add_op2_reg;
  logic [31:0]       out_result_reg;
  logic [TAG_W-1:0]  out_tag_reg;
  logic              out_timeout_reg;

  logic              fifo_full, fifo_empty;
  logic [TAG_W-1:0]  head_tag;
  logic [31:0]       head_op1, head_op2;
  logic              completion, expired;

  fp_req_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W + 64)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (InValid && InReady),
    .push_data ({InTag, InOp1, InOp2}),
    .pop       (state_reg == ISSUE),
    .head_data ({head_tag, head_op1, head_op2}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (Count)
  );

  assign InReady    = !fifo_full;
  assign completion = (cnt_reg >= MIN_LAT_C) && AddResultValid;
  assign expired    = (cnt_reg == LAST_C);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a completion on the expiry cycle still counts as a completion
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (completion || expired) state_next = HOLD;
      HOLD:    if (OutReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand, watchdog and result registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      add_op1_reg     <= '0;
      add_op2_reg     <= '0;
      cnt_reg         <= '0;
      out_result_reg  <= '0;
      out_tag_reg     <= '0;
      out_timeout_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && !fifo_empty) begin
        add_op1_reg <= head_op1;
        add_op2_reg <= head_op2;
      end
      if (state_reg == ISSUE) begin
        out_tag_reg <= head_tag;
        cnt_reg     <= '0;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == WAIT) begin
        if (completion) begin
          out_result_reg  <= AddResult;
          out_timeout_reg <= 1'b0;
        end else if (expired) begin
          out_result_reg  <= FP_QNAN;
          out_timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign AddOp1        = add_op1_reg;
  assign AddOp2        = add_op2_reg;
  assign AddInputValid = (state_reg == ISSUE);
  assign OutValid      = (state_reg == HOLD);
  assign OutResult     = out_result_reg;
  assign OutTag        = out_tag_reg;
  assign OutTimeout    = out_timeout_reg;

endmodule
